// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit with branch redirect (define IF_PERF_CNT_EN to add the fetch_count accept counter)
module instr_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [63:0] instr_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);
    typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] drain_addr_q, drain_addr_d;
    logic [63:0] instr_pc_q, instr_pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [63:0] redirect_pc;

    assign redirect_pc = branch_target & ~64'h3;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // next state: a redirect without ack must wait out the in-flight request in DRAIN
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = branch_taken ? (imem_ack ? FETCH : DRAIN) : (imem_ack ? HOLD : FETCH);
            HOLD:    state_d = (branch_taken || instr_ready) ? FETCH : HOLD;
            DRAIN:   state_d = imem_ack ? FETCH : DRAIN;
            default: state_d = FETCH;
        endcase
    end

    // memory request outputs: DRAIN keeps presenting the abandoned request's address
    always_comb begin
        imem_req  = state_q != HOLD;
        imem_addr = state_q == DRAIN ? drain_addr_q : pc_q;
    end

    // datapath next values: redirect has priority over ack and ready
    always_comb begin
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        valid_d      = valid_q;
        if (branch_taken) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            if (state_q == FETCH && !imem_ack) drain_addr_d = pc_q;
        end else if (state_q == FETCH && imem_ack) begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 64'd4;
            valid_d    = 1'b1;
        end else if (state_q == HOLD && instr_ready) begin
            valid_d = 1'b0;
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            instr_q      <= 32'h0;
            instr_pc_q   <= 64'h0;
            valid_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            valid_q      <= valid_d;
        end
    end

    assign instr_valid = valid_q;
    assign instruction = instr_q;
    assign instr_pc    = instr_pc_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count_q;

    // count words handed to the decoder, wrapping naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       fetch_count_q <= 32'h0;
        else if (valid_q && instr_ready)  fetch_count_q <= fetch_count_q + 32'd1;
    end

    assign fetch_count = fetch_count_q;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a transaction-level fetch model
module tb_instr_fetch;
    localparam logic [63:0] RST_PC = 64'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        branch_taken = 1'b0;
    logic [63:0] branch_target = 64'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [63:0] instr_pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc)
`ifdef IF_PERF_CNT_EN
        , .fetch_count(fetch_count)
`endif
    );

    typedef struct packed {logic [31:0] w; logic [63:0] pc;} word_t;
    word_t sb[$];

    logic [63:0] m_pc, m_old;
    bit          m_hold, m_stale, const_mem;
    int unsigned wait_n, lat;
    logic [31:0] m_cnt;

    function automatic logic [31:0] mem(input logic [63:0] a);
        return const_mem ? 32'h8B020020 : ((a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h0BADF00D);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_old = RST_PC; m_hold = 0; m_stale = 0; wait_n = 0; m_cnt = 0;
        sb.delete();
    endtask

    // assert reset mid-cycle, check outputs immediately, release away from an edge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req", imem_req, 1);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instruction, 0);
        chk("rst_ipc", instr_pc, 0);
        @(negedge clk);
        @(posedge clk);
        #2;
        branch_taken = 0; instr_ready = 0; imem_ack = 0;
        rst_n = 1'b1;
        model_reset();
    endtask

    // one clock: check request side against the model, drive inputs, advance the model
    task automatic step(input bit rdy, input bit br, input logic [63:0] tgt);
        @(negedge clk);
        chk("imem_req", imem_req, !m_hold);
        chk("instr_valid", instr_valid, m_hold);
        if (!m_hold) chk("imem_addr", imem_addr, m_stale ? m_old : m_pc);
`ifdef IF_PERF_CNT_EN
        chk("fetch_count", fetch_count, m_cnt);
`endif
        instr_ready = rdy; branch_taken = br; branch_target = tgt;
        if (imem_req && wait_n >= lat) begin
            imem_ack = 1; imem_rdata = mem(imem_addr); wait_n = 0;
        end else begin
            imem_ack = 0; imem_rdata = $urandom;
            wait_n = imem_req ? wait_n + 1 : 0;
        end
        if (m_hold) begin
            if (rdy) m_cnt++;
            if (br || rdy) m_hold = 0;
        end else if (imem_ack) begin
            if (!m_stale && !br) begin
                sb.push_back({mem(m_pc), m_pc});
                m_pc += 64'd4;
                m_hold = 1;
            end
            m_stale = 0;
        end else if (br && !m_stale) begin
            m_old = m_pc;
            m_stale = 1;
        end
        if (br) m_pc = tgt & ~64'h3;
    endtask

    // monitor: every newly presented word must be the next expected one and stay stable while held
    word_t cur;
    bit    prev_v = 0;
    initial forever begin
        @(negedge clk);
        #1;
        if (!rst_n) prev_v = 0;
        else begin
            if (instr_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL spurious_valid: got word at pc %h expected none", instr_pc);
                end else begin
                    cur = sb.pop_front();
                    chk("instruction", instruction, cur.w);
                    chk("instr_pc", instr_pc, cur.pc);
                end
            end else if (instr_valid) begin
                chk("held_instr", instruction, cur.w);
                chk("held_pc", instr_pc, cur.pc);
            end
            prev_v = instr_valid;
        end
    end

    initial begin
        const_mem = 1; lat = 0;
        do_reset();
        repeat (6) step(1, 0, 0);
        step(0, 0, 0);
        repeat (5) step(0, 0, 0);
        step(1, 0, 0);
        const_mem = 0;
        step(0, 1, 64'h103);
        step(1, 0, 0);
        step(1, 0, 0);
        lat = 3;
        step(0, 1, 64'h200);
        repeat (8) step(1, 0, 0);
        lat = 5;
        for (int i = 0; i < 4 && m_hold; i++) step(1, 0, 0);
        step(0, 1, 64'h300);
        step(0, 0, 0);
        #2;
        do_reset();
        lat = 0;
        repeat (4) step(1, 0, 0);
        repeat (400) begin
            lat = $urandom_range(0, 3);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, {$urandom, $urandom});
        end
`ifdef IF_PERF_CNT_EN
        lat = 0;
        do_reset();
        force dut.fetch_count_q = 32'hFFFFFFFE;
        #1;
        release dut.fetch_count_q;
        m_cnt = 32'hFFFFFFFE;
        repeat (4) step(1, 0, 0);
        step(0, 1, 64'h40);
        repeat (2) step(1, 0, 0);
        @(negedge clk);
        chk("count_wrap", fetch_count, 32'h1);
        branch_taken = 0; instr_ready = 0; imem_ack = 0;
`endif
        step(0, 0, 0);
        @(negedge clk);
        #2;
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
